// File: rtl/zero_check_arb.sv
// zero_check_arb: round-robin arbiter sharing one 64-bit zero detector.
// Optional sticky flag register: define ZCA_FLAG_REG_EN.

module nor64 (
  input  logic [63:0] data,
  output logic        zero
);

  logic [15:0] l1;
  logic [3:0]  l2;

  // three-level reduction: 4-bit ORs, then 4-wide ORs, then final NOR
  always_comb begin
    l1 = '0;
    l2 = '0;
    for (int i = 0; i < 16; i++)
      l1[i] = |data[4*i +: 4];
    for (int j = 0; j < 4; j++)
      l2[j] = |l1[4*j +: 4];
  end

  assign zero = ~|l2;

endmodule

module zero_check_arb #(
  parameter int WIDTH = 64,
  parameter int NREQ  = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       req_ready,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [1:0]            resp_id,
  output logic                  resp_zero,
  output logic                  z_flag
);

  if (WIDTH != 64) begin : g_bad_width
    $error("zero_check_arb: WIDTH must be 64");
  end

  if (NREQ < 2 || NREQ > 4) begin : g_bad_nreq
    $error("zero_check_arb: NREQ must be 2..4");
  end

  typedef struct packed {
    logic             valid;
    logic [1:0]       id;
    logic [WIDTH-1:0] data;
  } s1_t;

  typedef struct packed {
    logic       valid;
    logic [1:0] id;
    logic       zero;
  } s2_t;

  s1_t              s1;
  s2_t              s2;
  logic [1:0]       last;
  logic [NREQ-1:0]  grant;
  logic [1:0]       gnt_id;
  logic [WIDTH-1:0] gnt_data;
  logic             any;
  logic             s1_free;
  logic             s2_free;
  logic             accept;
  logic             det_zero;

  assign s2_free = !s2.valid | resp_ready;
  assign s1_free = !s1.valid | s2_free;

  // round-robin pick, first valid requester after the last winner
  always_comb begin
    grant  = '0;
    gnt_id = '0;
    any    = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!any && req_valid[i] &&
            (i == (int'(last) + 1 + k) % NREQ)) begin
          any      = 1'b1;
          grant[i] = 1'b1;
          gnt_id   = 2'(i);
        end
      end
    end
  end

  // operand mux for the granted requester
  always_comb begin
    gnt_data = '0;
    for (int i = 0; i < NREQ; i++)
      if (grant[i])
        gnt_data = req_data[i*WIDTH +: WIDTH];
  end

  assign req_ready = grant & {NREQ{s1_free}};
  assign accept    = any & s1_free;

  nor64 u_nor (
    .data (s1.data),
    .zero (det_zero)
  );

  // two-stage pipeline and round-robin pointer
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1   <= '0;
      s2   <= '0;
      last <= 2'(NREQ - 1);
    end else begin
      if (s1_free) begin
        s1.valid <= accept;
        if (accept) begin
          s1.id   <= gnt_id;
          s1.data <= gnt_data;
          last    <= gnt_id;
        end
      end
      if (s2_free) begin
        s2.valid <= s1.valid;
        if (s1.valid) begin
          s2.id   <= s1.id;
          s2.zero <= det_zero;
        end
      end
    end
  end

  assign resp_valid = s2.valid;
  assign resp_id    = s2.id;
  assign resp_zero  = s2.zero;

`ifdef ZCA_FLAG_REG_EN
  // sticky flag follows id-0 (flag-setting ALU) responses only
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      z_flag <= 1'b0;
    else if (s2.valid && resp_ready && s2.id == 2'd0)
      z_flag <= s2.zero;
  end
`else
  assign z_flag = 1'b0;
`endif

endmodule

// File: tb/tb_zero_check_arb.sv
// tb_zero_check_arb: directed and random checks of zero_check_arb
// against a queue-based latency/capacity model.

module tb_zero_check_arb;

  localparam int W = 64;
  localparam int N = 2;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [N*W-1:0] req_data = '0;
  logic [N-1:0]   req_ready;
  logic           resp_valid;
  logic           resp_ready = 1'b0;
  logic [1:0]     resp_id;
  logic           resp_zero;
  logic           z_flag;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  zero_check_arb #(.WIDTH(W), .NREQ(N)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_zero  (resp_zero),
    .z_flag     (z_flag)
  );

  typedef struct {
    int id;
    bit zero;
    int age;
  } ent_t;

  ent_t         q[$];
  int           m_last;
  bit           m_flag;
  logic [W-1:0] src0[$];
  logic [W-1:0] src1[$];
  bit [N-1:0]   pv;
  logic [W-1:0] pd[N];
  int           n_acc;
  int           n_resp;
  int           acc_ids[$];

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic present();
    if (!pv[0] && src0.size() > 0) begin
      pv[0] = 1'b1;
      pd[0] = src0.pop_front();
    end
    if (!pv[1] && src1.size() > 0) begin
      pv[1] = 1'b1;
      pd[1] = src1.pop_front();
    end
    req_valid = pv;
    req_data  = {pd[1], pd[0]};
  endtask

  task automatic step(input bit rr);
    int           win;
    int           idx;
    bit           full;
    bit           exp_rv;
    logic [N-1:0] exp_rdy;
    present();
    resp_ready = rr;
    #1;
    full = (q.size() == 2) && !rr;
    win  = -1;
    for (int k = 0; k < N; k++) begin
      idx = (m_last + 1 + k) % N;
      if (win < 0 && pv[idx]) win = idx;
    end
    exp_rdy = '0;
    if (win >= 0 && !full) exp_rdy[win] = 1'b1;
    exp_rv = (q.size() > 0) && (q[0].age >= 1);
    chk("req_ready", 64'(req_ready), 64'(exp_rdy));
    chk("resp_valid", 64'(resp_valid), 64'(exp_rv));
    if (exp_rv) begin
      chk("resp_id", 64'(resp_id), 64'(q[0].id));
      chk("resp_zero", 64'(resp_zero), 64'(q[0].zero));
    end
    chk("z_flag", 64'(z_flag), 64'(m_flag));
    if (|(req_valid & req_ready)) begin
      n_acc++;
      acc_ids.push_back(req_ready[1] ? 1 : 0);
    end
    if (resp_valid && resp_ready) n_resp++;
    @(posedge clk);
    if (exp_rv && rr) begin
`ifdef ZCA_FLAG_REG_EN
      if (q[0].id == 0) m_flag = q[0].zero;
`endif
      void'(q.pop_front());
    end
    foreach (q[j]) q[j].age++;
    if (win >= 0 && !full) begin
      q.push_back('{id: win, zero: (pd[win] == '0), age: 0});
      m_last  = win;
      pv[win] = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic model_reset();
    q.delete();
    src0.delete();
    src1.delete();
    m_last = N - 1;
    m_flag = 1'b0;
    pv     = '0;
    pd[0]  = '0;
    pd[1]  = '0;
  endtask

  task automatic apply_reset();
    reset_n   = 1'b0;
    model_reset();
    req_valid = '0;
    req_data  = '0;
    #1;
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_resp_id", 64'(resp_id), 64'd0);
    chk("rst_resp_zero", 64'(resp_zero), 64'd0);
    chk("rst_z_flag", 64'(z_flag), 64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  function automatic bit busy();
    return q.size() > 0 || src0.size() > 0 ||
           src1.size() > 0 || pv != '0;
  endfunction

  task automatic drain(input int maxc, output int n);
    n = 0;
    while (busy() && n < maxc) begin
      step(1'b1);
      n++;
    end
    if (busy()) chk("drain_timeout", 64'd1, 64'd0);
  endtask

  initial begin
    int           n;
    logic [W-1:0] v;

    apply_reset();

    // single zero operand from requester 0
    src0.push_back('0);
    drain(20, n);
    chk("single_cycles", 64'(n), 64'd3);

    // walking one on requester 1
    n_resp = 0;
    for (int s = 0; s < 64; s++) begin
      v = 64'd1 << s;
      src1.push_back(v);
    end
    src1.push_back(64'h8000_0000_0000_0000);
    drain(200, n);
    chk("walk_resp_count", 64'(n_resp), 64'd65);
    chk("walk_no_bubble", 64'(n), 64'd67);

    // fairness with both requesters busy
    apply_reset();
    acc_ids.delete();
    for (int j = 0; j < 8; j++) begin
      src0.push_back(64'h0);
      src1.push_back(64'h5);
    end
    drain(100, n);
    chk("fair_count", 64'(acc_ids.size()), 64'd16);
    foreach (acc_ids[j])
      chk("fair_order", 64'(acc_ids[j]), 64'(j % 2));

    // backpressure: five stalled cycles
    n_acc  = 0;
    n_resp = 0;
    src0.push_back(64'h0);
    src0.push_back(64'h3);
    src0.push_back(64'h0);
    for (int j = 0; j < 5; j++) step(1'b0);
    chk("bp_accepted", 64'(n_acc), 64'd2);
    drain(50, n);
    chk("bp_resp_count", 64'(n_resp), 64'd3);

    // asynchronous reset with both stages full
    src0.push_back(64'h5);
    src0.push_back(64'h0);
    for (int j = 0; j < 3; j++) step(1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_rst_valid", 64'(resp_valid), 64'd0);
    model_reset();
    req_valid = '0;
    @(negedge clk);
    reset_n = 1'b1;
    n_resp  = 0;
    for (int j = 0; j < 4; j++) step(1'b1);
    chk("no_stale_resp", 64'(n_resp), 64'd0);

`ifdef ZCA_FLAG_REG_EN
    // flag follows id 0 only
    src0.push_back(64'h0);
    drain(20, n);
    chk("flag_set", 64'(z_flag), 64'd1);
    for (int j = 0; j < 3; j++) src1.push_back(64'h0);
    drain(20, n);
    chk("flag_hold_id1", 64'(z_flag), 64'd1);
    src0.push_back(64'h40);
    drain(20, n);
    chk("flag_clear", 64'(z_flag), 64'd0);
`endif

    // random traffic and random backpressure
    for (int c = 0; c < 1500; c++) begin
      if (src0.size() < 2 && $urandom_range(0, 2) != 0) begin
        v = ($urandom_range(0, 2) == 0) ? '0 :
            {32'($urandom), 32'($urandom)};
        src0.push_back(v);
      end
      if (src1.size() < 2 && $urandom_range(0, 2) != 0) begin
        v = ($urandom_range(0, 2) == 0) ? '0 :
            (64'd1 << $urandom_range(0, 63));
        src1.push_back(v);
      end
      step($urandom_range(0, 3) != 0);
    end
    drain(100, n);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
